// File: rtl/axis_tile_source_pkg.sv
// Shared definitions for the tile source: state encoding, count clamping and bus width.
package axis_tile_source_pkg;

  localparam logic STATE_IDLE   = 1'b0;
  localparam logic STATE_STREAM = 1'b1;

  typedef enum logic {
    IDLE   = STATE_IDLE,
    STREAM = STATE_STREAM
  } state_t;

  // A zero or oversized request means "send the whole storage".
  function automatic int unsigned clamp_count(input int unsigned count, input int unsigned depth);
    return ((count == 0) || (count > depth)) ? depth : count;
  endfunction

  function automatic int unsigned bus_width(input int unsigned lanes, input int unsigned data_width);
    return lanes * data_width;
  endfunction

endpackage

// File: rtl/axis_tile_source_tile_row_mem.sv
// Row storage: synchronous write, asynchronous read, contents survive reset.
module tile_row_mem #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/axis_tile_source.sv
// AXI-stream master that replays a stored tile of row vectors, one row per beat, TLAST on the final row.
module axis_tile_source
  import axis_tile_source_pkg::*;
#(
  parameter int unsigned N          = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 wr_en,
  input  logic [ADDR_W-1:0]                    wr_addr,
  input  logic [bus_width(N, DATA_WIDTH)-1:0]  wr_data,
  output logic                                 wr_err,
  input  logic [ADDR_W:0]                      row_count,
  input  logic                                 start,
  output logic                                 busy,
  output logic                                 done,
  output logic [bus_width(N, DATA_WIDTH)-1:0]  tdata,
  output logic                                 tvalid,
  output logic                                 tlast,
  input  logic                                 tready
);

  localparam int unsigned W = bus_width(N, DATA_WIDTH);

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] last_idx;
  logic [ADDR_W-1:0] rd_addr;
  logic [W-1:0]      rd_data;
  logic              wr_ok;
  logic              handshake;
  int unsigned       start_count;

  assign wr_ok       = wr_en && (state == IDLE) && (32'(wr_addr) < DEPTH);
  assign start_count = clamp_count(32'(row_count), DEPTH);
  assign handshake   = tvalid && tready;
  // In IDLE the read port already points at row 0 so the first beat loads on the start edge.
  assign rd_addr     = (state == IDLE) ? '0 : ptr;

  tile_row_mem #(
    .DEPTH  (DEPTH),
    .WIDTH  (W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_addr),
    .wdata (wr_data),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= '0;
      last_idx <= '0;
      tdata    <= '0;
      tvalid   <= 1'b0;
      tlast    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      done   <= 1'b0;
      wr_err <= wr_en && !wr_ok;
      case (state)
        IDLE: begin
          if (start) begin
            tdata    <= rd_data;
            tvalid   <= 1'b1;
            tlast    <= (start_count == 32'd1);
            busy     <= 1'b1;
            ptr      <= ADDR_W'(1);
            last_idx <= ADDR_W'(start_count - 32'd1);
            state    <= STREAM;
          end
        end
        STREAM: begin
          if (handshake) begin
            if (tlast) begin
              tvalid <= 1'b0;
              tlast  <= 1'b0;
              busy   <= 1'b0;
              done   <= 1'b1;
              ptr    <= '0;
              state  <= IDLE;
            end else begin
              // Without a handshake every output register simply holds.
              tdata <= rd_data;
              tlast <= (ptr == last_idx);
              ptr   <= ptr + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_tile_source.sv
// Self-checking bench for axis_tile_source against a row-array/stream reference model.
module tb_axis_tile_source;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        wr_err;
  logic [3:0]  row_count = '0;
  logic        start = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready = 1'b0;

  logic [31:0] ref_rows [DEPTH];
  int check_count = 0;
  int pass_count  = 0;

  axis_tile_source #(
    .N          (4),
    .DATA_WIDTH (8),
    .DEPTH      (DEPTH),
    .ADDR_W     (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_err    (wr_err),
    .row_count (row_count),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .tdata     (tdata),
    .tvalid    (tvalid),
    .tlast     (tlast),
    .tready    (tready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got !== exp) begin
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      pass_count++;
    end
  endtask

  task automatic write_row(input logic [2:0] addr, input logic [31:0] data);
    bit exp_err;
    exp_err = (int'(addr) >= DEPTH);
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
    check("wr_err", {31'b0, wr_err}, {31'b0, exp_err});
    if (!exp_err) ref_rows[addr[1:0]] = data;
    $display("write addr=%0d data=%h err=%0b", addr, data, wr_err);
    @(negedge clk);
    check("wr_err_clear", {31'b0, wr_err}, 32'd0);
  endtask

  function automatic bit pick_ready(input int mode, input int cyc);
    bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc < 7) ? pat[cyc] : 1'b1;
    return 1'($urandom_range(0, 1));
  endfunction

  // Called at a negedge with the first beat already on the bus.
  task automatic drain(input int c, input int mode, input string tag);
    int idx = 0;
    int cyc = 0;
    int busy_cycles = 0;
    bit stalled = 0;
    logic [31:0] prev_data = '0;
    logic prev_last = 1'b0;
    while (idx < c && cyc < 200) begin
      if (busy) busy_cycles++;
      if (stalled) begin
        check({tag, "_stall_data"}, tdata, prev_data);
        check({tag, "_stall_last"}, {31'b0, tlast}, {31'b0, prev_last});
      end
      tready = pick_ready(mode, cyc);
      if (tvalid && tready) begin
        check({tag, "_data"}, tdata, ref_rows[idx]);
        check({tag, "_last"}, {31'b0, tlast}, {31'b0, (idx == c - 1)});
        $display("%s beat %0d data=%h last=%0b", tag, idx, tdata, tlast);
        idx++;
        stalled = 0;
      end else begin
        check({tag, "_valid_hold"}, {31'b0, tvalid}, 32'd1);
        stalled = 1;
        prev_data = tdata;
        prev_last = tlast;
      end
      cyc++;
      @(negedge clk);
    end
    check({tag, "_beats"}, idx, c);
    check({tag, "_busy_cycles"}, busy_cycles, cyc);
    if (mode == 0) check({tag, "_cycles"}, cyc, c);
    check({tag, "_done"}, {31'b0, done}, 32'd1);
    check({tag, "_busy_end"}, {31'b0, busy}, 32'd0);
    check({tag, "_valid_end"}, {31'b0, tvalid}, 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
    check({tag, "_idle_valid"}, {31'b0, tvalid}, 32'd0);
  endtask

  task automatic send_tile(input int rc, input int mode, input string tag);
    int c;
    c = (rc == 0 || rc > DEPTH) ? DEPTH : rc;
    tready = 1'b0; row_count = 4'(rc); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, "_start_valid"}, {31'b0, tvalid}, 32'd1);
    check({tag, "_start_busy"}, {31'b0, busy}, 32'd1);
    drain(c, mode, tag);
    $display("%s tile rc=%0d beats=%0d complete", tag, rc, c);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_tvalid", {31'b0, tvalid}, 32'd0);
    check("rst_tlast", {31'b0, tlast}, 32'd0);
    check("rst_tdata", tdata, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_wr_err", {31'b0, wr_err}, 32'd0);

    for (int i = 0; i < DEPTH; i++)
      write_row(3'(i), {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});

    send_tile(4, 0, "full");
    send_tile(4, 1, "pattern");
    send_tile(1, 0, "single");
    send_tile(0, 0, "clamp0");

    // Busy: a write and a second start must both be ignored.
    tready = 1'b0; row_count = 4'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 32'hDEADBEEF; start = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; start = 1'b0;
    check("busy_wr_err", {31'b0, wr_err}, 32'd1);
    check("busy_hold_data", tdata, ref_rows[0]);
    $display("busy write rejected err=%0b", wr_err);
    drain(4, 0, "busy");
    send_tile(4, 0, "after_busy");

    // Reset with the third beat stalled on the bus.
    tready = 1'b0; row_count = 4'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0; tready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tready = 1'b0;
    check("pre_rst_data", tdata, ref_rows[2]);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_valid", {31'b0, tvalid}, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_last", {31'b0, tlast}, 32'd0);
    @(negedge clk);
    check("abort_no_done", {31'b0, done}, 32'd0);
    $display("mid-transfer reset aborted tile");
    send_tile(4, 0, "after_reset");

    write_row(3'd4, 32'h12345678);
    send_tile(4, 0, "after_oob");

    for (int it = 0; it < 8; it++) begin
      write_row(3'($urandom_range(0, 5)), $urandom);
      write_row(3'($urandom_range(0, 5)), $urandom);
      send_tile(int'($urandom_range(0, 9)), 2, "rand");
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
